// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM download -> SDRAM word-write loader.
package rom_loader_pkg;

    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_BOTH = 2'b11;

    typedef struct packed {
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } fifo_entry_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two >= 2.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    count_q;

    assign dout_o  = mem_q[rd_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            assert (!(push_i && full_o && !pop_i))
                else $error("sync_fifo: push while full");
            assert (!(pop_i && empty_o))
                else $error("sync_fifo: pop while empty");
            if (push_i) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rom_loader_sdram.sv
// Pairs HPS download bytes into 16-bit words, buffers them, and issues them
// as toggle-handshake writes on one SDRAM controller request port.
module rom_loader_sdram
    import rom_loader_pkg::*;
#(
    parameter logic [22:0] BASE_WADDR = 23'h000000,
    parameter logic [7:0]  IDX        = 8'd0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        busy,
    output logic        done,
    output logic        sd_req,
    input  logic        sd_ack,
    output logic        sd_we,
    output logic [22:0] sd_a,
    output logic [1:0]  sd_ds,
    output logic [15:0] sd_d
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic        active;
    logic        wr_acc;
    logic [22:0] byte_waddr;
    logic        unused_addr_msb;

    logic        pend_q, pend_d;
    logic [22:0] pend_a_q, pend_a_d;
    logic [7:0]  pend_lo_q, pend_lo_d;

    logic        push;
    fifo_entry_t push_entry;
    fifo_entry_t fifo_head;
    logic [CW-1:0] fifo_count;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [22:0] a_q, a_d;
    logic [1:0]  ds_q, ds_d;
    logic [15:0] d_q, d_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        drain_idle;

    assign active     = ioctl_download && (ioctl_index == IDX);
    assign wr_acc     = active && ioctl_wr;
    // Bit 24 of the byte address falls outside the 23-bit word space (wraps).
    assign byte_waddr = BASE_WADDR + ioctl_addr[23:1];
    assign unused_addr_msb = ioctl_addr[24];

    always_comb begin
        pend_d     = pend_q;
        pend_a_d   = pend_a_q;
        pend_lo_d  = pend_lo_q;
        push       = 1'b0;
        push_entry = '0;
        if (wr_acc) begin
            if (!ioctl_addr[0]) begin
                if (pend_q && (pend_a_q != byte_waddr)) begin
                    push       = 1'b1;
                    push_entry = '{a: pend_a_q, ds: DS_LO, d: {8'h00, pend_lo_q}};
                end
                pend_d    = 1'b1;
                pend_a_d  = byte_waddr;
                pend_lo_d = ioctl_dout;
            end else if (pend_q && (pend_a_q == byte_waddr)) begin
                push       = 1'b1;
                push_entry = '{a: byte_waddr, ds: DS_BOTH, d: {ioctl_dout, pend_lo_q}};
                pend_d     = 1'b0;
            end else begin
                // A stray high byte goes out alone; any unrelated pending low byte stays latched.
                push       = 1'b1;
                push_entry = '{a: byte_waddr, ds: DS_HI, d: {ioctl_dout, 8'h00}};
            end
        end else if (!active && pend_q && !fifo_full) begin
            push       = 1'b1;
            push_entry = '{a: pend_a_q, ds: DS_LO, d: {8'h00, pend_lo_q}};
            pend_d     = 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   (push_entry),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        a_d     = a_q;
        ds_d    = ds_q;
        d_d     = d_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && (req_q == sd_ack)) begin
                    a_d     = fifo_head.a;
                    ds_d    = fifo_head.ds;
                    d_d     = fifo_head.d;
                    we_d    = 1'b1;
                    req_d   = ~req_q;
                    pop     = 1'b1;
                    state_d = S_WAIT;
                end else if (fifo_empty) begin
                    we_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (sd_ack == req_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign drain_idle = !active && !pend_q && fifo_empty &&
                        (state_q == S_IDLE) && (req_q == sd_ack);

    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        if (wr_acc) begin
            busy_d = 1'b1;
        end else if (busy_q && drain_idle) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q    <= 1'b0;
            pend_a_q  <= '0;
            pend_lo_q <= '0;
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            a_q       <= '0;
            ds_q      <= '0;
            d_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            pend_a_q  <= pend_a_d;
            pend_lo_q <= pend_lo_d;
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            a_q       <= a_d;
            ds_q      <= ds_d;
            d_q       <= d_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ioctl_wait = (fifo_count >= CW'(FIFO_DEPTH - 1));
    assign busy       = busy_q;
    assign done       = done_q;
    assign sd_req     = req_q;
    assign sd_we      = we_q;
    assign sd_a       = a_q;
    assign sd_ds      = ds_q;
    assign sd_d       = d_q;

endmodule

// File: tb/tb_rom_loader_sdram.sv
// Randomised bench for rom_loader_sdram: byte runs in, SDRAM writes checked
// against word-level expectations derived from each run's address range.
module tb_rom_loader_sdram;

    localparam logic [22:0] BASE  = 23'h000100;
    localparam logic [7:0]  IDXV  = 8'h05;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        busy;
    logic        done;
    logic        sd_req;
    logic        sd_ack;
    logic        sd_we;
    logic [22:0] sd_a;
    logic [1:0]  sd_ds;
    logic [15:0] sd_d;

    int   checks = 0;
    int   errors = 0;
    wr_t  got_q[$];
    wr_t  exp_q[$];
    wr_t  ctl_cap;
    logic ctl_busy;
    int   ctl_left;
    logic slow_mode = 1'b0;
    int   done_cnt;
    logic busy_seen;
    logic wait_seen;
    int   wait_bytes;
    int   bytes_sent;
    logic [7:0] pay [16];

    always #5 clk = ~clk;

    rom_loader_sdram #(
        .BASE_WADDR (BASE),
        .IDX        (IDXV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .busy           (busy),
        .done           (done),
        .sd_req         (sd_req),
        .sd_ack         (sd_ack),
        .sd_we          (sd_we),
        .sd_a           (sd_a),
        .sd_ds          (sd_ds),
        .sd_d           (sd_d)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // SDRAM controller model: captures a write on each req toggle, acks later.
    initial begin
        sd_ack   = 1'b0;
        ctl_busy = 1'b0;
        ctl_left = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sd_ack   = 1'b0;
                ctl_busy = 1'b0;
            end else if (!ctl_busy) begin
                if (sd_req != sd_ack) begin
                    ctl_cap = '{a: sd_a, ds: sd_ds, d: sd_d};
                    chk("sd_we_on_issue", sd_we, 1'b1);
                    got_q.push_back(ctl_cap);
                    ctl_busy = 1'b1;
                    ctl_left = slow_mode ? 20 : int'($urandom_range(1, 6));
                end
            end else begin
                ctl_left--;
                if (ctl_left == 0) begin
                    chk("hold_a", sd_a, ctl_cap.a);
                    chk("hold_ds", sd_ds, ctl_cap.ds);
                    chk("hold_d", sd_d, ctl_cap.d);
                    sd_ack   = ~sd_ack;
                    ctl_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                chk("busy_low_at_done", busy, 1'b0);
            end
            if (busy) busy_seen = 1'b1;
            if (ioctl_wait && !wait_seen) begin
                wait_seen  = 1'b1;
                wait_bytes = bytes_sent;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
        int k = 0;
        while (ioctl_wait && k < 300) begin
            tick();
            k++;
        end
        if (k >= 300) chk("wait_timeout", 1'b1, 1'b0);
        ioctl_wr   = 1'b1;
        ioctl_addr = addr;
        ioctl_dout = data;
        bytes_sent++;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
    endtask

    // Expected writes: one per word touched by the byte range, strobes cover the bytes present.
    task automatic build_expect(input int start, input int n);
        int first_w = start / 2;
        int last_w  = (start + n - 1) / 2;
        exp_q.delete();
        for (int w = first_w; w <= last_w; w++) begin
            wr_t e;
            logic lo_in = (2 * w >= start) && (2 * w <= start + n - 1);
            logic hi_in = (2 * w + 1 >= start) && (2 * w + 1 <= start + n - 1);
            e.a  = 23'(int'(BASE) + w);
            e.ds = {hi_in, lo_in};
            e.d  = {hi_in ? pay[2 * w + 1 - start] : 8'h00,
                    lo_in ? pay[2 * w - start]     : 8'h00};
            exp_q.push_back(e);
        end
    endtask

    task automatic run_session(input logic [7:0] idx, input int start, input int n,
                               input logic slow, input logic gaps);
        logic expect_done;
        int   k;
        got_q.delete();
        exp_q.delete();
        if (idx == IDXV && n > 0) build_expect(start, n);
        expect_done = (exp_q.size() > 0);
        done_cnt   = 0;
        busy_seen  = 1'b0;
        wait_seen  = 1'b0;
        wait_bytes = 0;
        bytes_sent = 0;
        slow_mode  = slow;
        ioctl_download = 1'b1;
        ioctl_index    = idx;
        for (int i = 0; i < n; i++) begin
            send_byte(25'(start + i), pay[i]);
            if (gaps) repeat ($urandom_range(0, 2)) tick();
        end
        ioctl_download = 1'b0;
        tick();
        k = 0;
        while (done_cnt == 0 && k < 600) begin
            tick();
            k++;
        end
        repeat (30) tick();
        chk("n_writes", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            logic [15:0] mask = {{8{exp_q[i].ds[1]}}, {8{exp_q[i].ds[0]}}};
            chk("wr_a", got_q[i].a, exp_q[i].a);
            chk("wr_ds", got_q[i].ds, exp_q[i].ds);
            chk("wr_d", got_q[i].d & mask, exp_q[i].d);
        end
        chk("done_count", 64'(done_cnt), expect_done ? 64'd1 : 64'd0);
        chk("busy_seen", busy_seen, expect_done);
        chk("busy_end", busy, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        repeat (3) tick();
        chk("rst_sd_req", sd_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wait", ioctl_wait, 1'b0);
        chk("rst_sd_we", sd_we, 1'b0);
        chk("rst_sd_bus", {sd_a, sd_ds, sd_d}, 41'd0);
        reset = 1'b0;
        tick();

        pay[0] = 8'h11;
        pay[1] = 8'h22;
        run_session(IDXV, 0, 2, 1'b0, 1'b0);
        chk("t1_fixed_d", got_q.size() > 0 ? {got_q[0].a, got_q[0].ds, got_q[0].d} : 41'd0,
            {23'h000100, 2'b11, 16'h2211});

        fill_random();
        run_session(IDXV, 0, 5, 1'b0, 1'b0);

        fill_random();
        run_session(IDXV, 0, 8, 1'b1, 1'b0);
        chk("slow_wait_seen", wait_seen, 1'b1);
        chk("slow_wait_at_byte", 64'(wait_bytes), 64'd8);

        fill_random();
        run_session(IDXV + 8'd1, 0, 16, 1'b0, 1'b1);

        pay[0] = 8'hAB;
        run_session(IDXV, 7, 1, 1'b0, 1'b0);
        chk("odd_hi_byte", got_q.size() > 0 ? {got_q[0].a, got_q[0].ds, got_q[0].d[15:8]} : 33'd0,
            {23'(BASE + 23'd3), 2'b10, 8'hAB});

        fill_random();
        run_session(IDXV, 32'h1FFFFFC, 4, 1'b0, 1'b0);

        for (int s = 0; s < 12; s++) begin
            fill_random();
            run_session(($urandom_range(0, 5) == 0) ? 8'h7E : IDXV,
                        int'($urandom_range(0, 300)), int'($urandom_range(1, 14)),
                        ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        fill_random();
        got_q.delete();
        slow_mode      = 1'b1;
        ioctl_download = 1'b1;
        ioctl_index    = IDXV;
        for (int i = 0; i < 8; i++) send_byte(25'(i), pay[i]);
        tick();
        chk("pre_rst_wait", ioctl_wait, 1'b1);
        reset          = 1'b1;
        ioctl_download = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_sd_req", sd_req, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_wait", ioctl_wait, 1'b0);
        chk("mid_rst_sd_we", sd_we, 1'b0);
        #1;
        reset = 1'b0;
        got_q.delete();
        done_cnt = 0;
        repeat (40) tick();
        chk("post_rst_writes", 64'(got_q.size()), 64'd0);
        chk("post_rst_done", 64'(done_cnt), 64'd0);
        chk("post_rst_busy", busy, 1'b0);

        fill_random();
        run_session(IDXV, 3, 9, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
